// File: rtl/oam_dma.sv
// oam_dma -- NES sprite DMA engine sitting beside the 6502 core.
//
// Purpose:
//   Watches CPU writes for the DMA register. A write of page value P halts
//   the core (rdy low) and copies P00..P(XFER_LEN-1) into OAMDATA as
//   alternating read/write bus cycles that the engine masters itself.
//
// Ports:
//   clk, rst          system clock (one CPU cycle per edge), sync active-high reset
//   cpu_addr          core address bus
//   cpu_data_out      core write data (carries the page number on trigger)
//   cpu_wen, cpu_ren  core write / read strobes
//   dma_data_in       bus read data, sampled at the end of each DMA read cycle
//   rdy               to core rdy; 0 halts the core on its next read cycle
//   dma_active        1 while the engine owns the bus (top-level mux select)
//   dma_addr          engine bus address
//   dma_ren, dma_wen  engine read / write strobes
//   dma_data_out      engine write data (byte captured in the previous read)
//   dbg_state         current FSM state encoding (observation only)
//   dbg_parity        current get/put parity (0 = get, 1 = put)
//
// Halt handshake: rdy is a level, not a pulse. Once rdy is low the core keeps
// running its write cycles (the 6502 ignores rdy on writes) and stops on its
// first read; that read cycle is the dummy cycle the engine waits for. The
// engine only drives the bus while dma_active is high and releases rdy in the
// cycle right after the final OAM write.
//
// All outputs are registered from next-state values, so each output reflects
// the state occupied during the same cycle, with no combinational path from
// cpu_* inputs.

module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  input  logic [7:0]  dma_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_ren,
  output logic        dma_wen,
  output logic [7:0]  dma_data_out,
  output logic [2:0]  dbg_state,
  output logic        dbg_parity
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_ALIGN     = 3'd2,
    S_READ      = 3'd3,
    S_WRITE     = 3'd4
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        parity_q, parity_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic [15:0] addr_q, addr_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    parity_d = ~parity_q;
    data_d   = data_q;

    case (state_q)
      S_IDLE: begin
        // Only the CPU strobes can trigger, and only here, so the engine's
        // own OAM writes can never restart a transfer.
        if (cpu_wen && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_out;
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        // The first core read is the dummy cycle. Reads must land on get
        // (parity 0) cycles: if the dummy cycle is a put cycle the next one
        // is already a get, otherwise burn one ALIGN cycle.
        if (cpu_ren) begin
          state_d = parity_q ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        data_d  = dma_data_in;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    rdy_d    = (state_d == S_IDLE);
    active_d = (state_d == S_ALIGN) || (state_d == S_READ) || (state_d == S_WRITE);
    ren_d    = (state_d == S_READ);
    wen_d    = (state_d == S_WRITE);
    addr_d   = 16'h0000;
    if (state_d == S_READ) begin
      // idx is only 8 bits and the page byte is concatenated, so the source
      // address can never carry into the next page.
      addr_d = {page_d, idx_d};
    end else if (state_d == S_WRITE) begin
      addr_d = OAM_DATA_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      page_q   <= 8'd0;
      idx_q    <= 8'd0;
      parity_q <= 1'b0;
      data_q   <= 8'd0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= 16'h0000;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  assign rdy          = rdy_q;
  assign dma_active   = active_q;
  assign dma_addr     = addr_q;
  assign dma_ren      = ren_q;
  assign dma_wen      = wen_q;
  assign dma_data_out = data_q;
  assign dbg_state    = state_q;
  assign dbg_parity   = parity_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma -- directed bench for oam_dma.
// Inputs are driven and outputs sampled on the falling edge, so each sample
// shows the cycle whose inputs are being set at that moment.

module tb_oam_dma;

  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_REG = 16'h2004;
  localparam int          LEN     = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr     = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_wen      = 1'b0;
  logic        cpu_ren      = 1'b0;
  logic [7:0]  dma_data_in  = 8'h00;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_ren;
  logic        dma_wen;
  logic [7:0]  dma_data_out;
  logic [2:0]  dbg_state;
  logic        dbg_parity;

  oam_dma dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_wen      (cpu_wen),
    .cpu_ren      (cpu_ren),
    .dma_data_in  (dma_data_in),
    .rdy          (rdy),
    .dma_active   (dma_active),
    .dma_addr     (dma_addr),
    .dma_ren      (dma_ren),
    .dma_wen      (dma_wen),
    .dma_data_out (dma_data_out),
    .dbg_state    (dbg_state),
    .dbg_parity   (dbg_parity)
  );

  // Reference get/put parity: 0 in the first cycle after reset, toggling
  // every clock afterwards.
  logic exp_par = 1'b0;
  always @(posedge clk) exp_par <= rst ? 1'b0 : ~exp_par;

  // scoreboard
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model contents for the source page.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = a[7:0];
    hi = a[15:8];
    return (lo * 8'd3) + hi + 8'h11;
  endfunction

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_cpu(input logic wen, input logic ren, input logic [15:0] addr,
                           input logic [7:0] data);
    cpu_wen      = wen;
    cpu_ren      = ren;
    cpu_addr     = addr;
    cpu_data_out = data;
  endtask

  task automatic check_bus_quiet(input string tag);
    check({tag, "_rdy"},    32'(rdy),        32'd1);
    check({tag, "_active"}, 32'(dma_active), 32'd0);
    check({tag, "_ren"},    32'(dma_ren),    32'd0);
    check({tag, "_wen"},    32'(dma_wen),    32'd0);
    check({tag, "_state"},  32'(dbg_state),  32'd0);
  endtask

  // One complete transfer. pre = extra CPU write cycles between trigger and
  // the dummy read; want_par = parity of the dummy cycle; abort_at = index
  // whose read cycle gets reset applied (-1 for none).
  task automatic xfer(input logic [7:0] page, input int pre, input logic want_par,
                      input int abort_at);
    int halt_cnt;
    logic [15:0] ra;
    logic [7:0]  eb;
    halt_cnt = 0;
    exp_q.delete();
    drive_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    if ((exp_par ^ 1'b1 ^ pre[0]) != want_par) step();

    check("trig_idle_rdy", 32'(rdy), 32'd1);
    drive_cpu(1'b1, 1'b0, DMA_REG, page);
    step();

    for (int i = 0; i < pre; i++) begin
      check("pre_rdy",    32'(rdy),        32'd0);
      check("pre_active", 32'(dma_active), 32'd0);
      check("pre_ren",    32'(dma_ren),    32'd0);
      check("pre_wen",    32'(dma_wen),    32'd0);
      check("pre_state",  32'(dbg_state),  32'd1);
      // A second DMA-register write while halting must be ignored.
      drive_cpu(1'b1, 1'b0, (i == 0) ? DMA_REG : 16'h0300, 8'h77);
      step();
    end

    // dummy (halt) cycle
    check("dummy_rdy",    32'(rdy),        32'd0);
    check("dummy_active", 32'(dma_active), 32'd0);
    check("dummy_parity", 32'(dbg_parity), 32'(exp_par));
    if (!rdy) halt_cnt++;
    drive_cpu(1'b0, 1'b1, 16'h8000, 8'h00);
    step();
    drive_cpu(1'b0, 1'b0, 16'h8000, 8'h00);

    if (!want_par) begin
      check("align_active", 32'(dma_active), 32'd1);
      check("align_ren",    32'(dma_ren),    32'd0);
      check("align_wen",    32'(dma_wen),    32'd0);
      check("align_rdy",    32'(rdy),        32'd0);
      if (!rdy) halt_cnt++;
      step();
    end

    for (int i = 0; i < LEN; i++) begin
      ra = {page, 8'(i)};
      check("rd_active", 32'(dma_active), 32'd1);
      check("rd_ren",    32'(dma_ren),    32'd1);
      check("rd_wen",    32'(dma_wen),    32'd0);
      check("rd_rdy",    32'(rdy),        32'd0);
      check("rd_addr",   32'(dma_addr),   32'(ra));
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_rdy",    32'(rdy),          32'd1);
        check("abort_active", 32'(dma_active),   32'd0);
        check("abort_ren",    32'(dma_ren),      32'd0);
        check("abort_wen",    32'(dma_wen),      32'd0);
        check("abort_addr",   32'(dma_addr),     32'd0);
        check("abort_data",   32'(dma_data_out), 32'd0);
        check("abort_state",  32'(dbg_state),    32'd0);
        check("abort_parity", 32'(dbg_parity),   32'd0);
        step();
        return;
      end
      dma_data_in = mem_byte(dma_addr);
      exp_q.push_back(mem_byte(ra));
      if (!rdy) halt_cnt++;
      step();
      dma_data_in = 8'h00;

      eb = exp_q.pop_front();
      check("wr_active", 32'(dma_active),   32'd1);
      check("wr_wen",    32'(dma_wen),      32'd1);
      check("wr_ren",    32'(dma_ren),      32'd0);
      check("wr_rdy",    32'(rdy),          32'd0);
      check("wr_addr",   32'(dma_addr),     32'(OAM_REG));
      check("wr_data",   32'(dma_data_out), 32'(eb));
      if (!rdy) halt_cnt++;
      step();
    end

    check_bus_quiet("release");
    check("halt_cycles", 32'(halt_cnt), want_par ? 32'd513 : 32'd514);
  endtask

  initial begin
    drive_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b1;
    step();
    step();
    check_bus_quiet("reset");
    check("reset_addr",   32'(dma_addr),     32'd0);
    check("reset_data",   32'(dma_data_out), 32'd0);
    check("reset_parity", 32'(dbg_parity),   32'd0);
    rst = 1'b0;
    step();

    // Idle bus with near-miss accesses: none may trigger.
    for (int i = 0; i < 100; i++) begin
      check_bus_quiet("idle");
      case (i)
        10:      drive_cpu(1'b1, 1'b0, 16'h4013, 8'h02);
        20:      drive_cpu(1'b1, 1'b0, OAM_REG, 8'h02);
        30:      drive_cpu(1'b0, 1'b1, DMA_REG, 8'h02);
        default: drive_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
      endcase
      step();
    end

    xfer(8'h02, 0, 1'b1, -1);   // odd-aligned halt, 513 cycles
    xfer(8'h02, 0, 1'b0, -1);   // even-aligned halt, ALIGN inserted, 514
    xfer(8'h35, 2, 1'b1, -1);   // core finishes two writes before halting
    xfer(8'hFF, 0, 1'b0, -1);   // top page, no wrap past $FFFF
    xfer(8'h10, 0, 1'b1, 8'h40); // reset mid-transfer
    xfer(8'h11, 0, 1'b1, -1);   // clean restart from idx 0

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- NES sprite DMA engine on the CPU side of the bus, directly downstream of the 6502 core.
- Snoops CPU writes to the DMA register ($4014) and halts the core through its rdy input.
- Masters the bus itself to copy 256 bytes from CPU page $XX00-$XXFF into PPU OAMDATA ($2004).
- The top-level bus mux selects DMA address/strobes whenever dma_active is high.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer (must be a power of two, ≤256).

Ports:
- clk  in  1  system clock, one CPU cycle per edge.
- rst  in  1  synchronous reset, active-high.
- cpu_addr  in  16  core address output.
- cpu_data_out  in  8  core write data.
- cpu_wen  in  1  core write strobe.
- cpu_ren  in  1  core read strobe.
- dma_data_in  in  8  bus read data, valid during DMA read cycles.
- rdy  out  1  to core rdy; 0 halts core on its next read cycle.
- dma_active  out  1  1 = DMA owns bus (mux select).
- dma_addr  out  16  DMA bus address.
- dma_ren  out  1  DMA read strobe.
- dma_wen  out  1  DMA write strobe.
- dma_data_out  out  8  DMA write data.

Behaviour:
- Reset values: rdy=1, dma_active=0, dma_addr=0, dma_ren=0, dma_wen=0, dma_data_out=0, page=0, idx=0, parity=0, state=IDLE.
- Reset mid-transfer aborts immediately; outputs are at reset values the cycle after rst is sampled.
- Parity bit toggles every clk after reset; parity 0 = get (read) cycle, 1 = put (write) cycle.
- States: IDLE, HALT_WAIT, ALIGN, READ, WRITE.
- IDLE:
  - On cpu_wen=1 and cpu_addr==DMA_REG_ADDR, latch page=cpu_data_out and go to HALT_WAIT.
  - rdy=0 from the next cycle.
- HALT_WAIT:
  - rdy=0, dma_active=0.
  - The core may finish pending write cycles (rdy is ignored on writes).
  - The first cycle with cpu_ren=1 is the halt (dummy) cycle.
  - If parity is 1 in that cycle, go to READ; otherwise go to ALIGN.
- ALIGN: one idle cycle with dma_active=1 and no strobes; always goes to READ, which lands on parity 0.
- READ:
  - dma_active=1, dma_ren=1, dma_addr={page,idx}.
  - dma_data_in is captured into dma_data_out at the clk edge ending the cycle.
  - Next state is WRITE.
- WRITE:
  - dma_active=1, dma_wen=1, dma_addr=OAM_DATA_ADDR, dma_data_out holds the captured byte.
  - If idx==XFER_LEN-1: clear idx and go to IDLE, with rdy=1 and dma_active=0 the next cycle.
  - Otherwise: idx++ and go to READ.
- Total halt from the dummy cycle to rdy release: 513 cycles (odd-aligned halt) or 514 (even-aligned).
- idx is 8-bit and never wraps into the page byte; the source address stays within page.
- Writes to DMA_REG_ADDR while not in IDLE are ignored; the core cannot issue them while halted anyway.
- A DMA write to OAM_DATA_ADDR never retriggers (trigger only observes cpu_* signals, and only in IDLE).
- rdy and all dma_* outputs are registered; there is no combinational path from cpu_* inputs to outputs.

Test Plan:
- Reset, idle bus: rdy=1, dma_active=0, no strobes for 100 cycles; a CPU write to $4013 causes no response.
- Write $02→$4014, cpu_ren=1 on the next cycle with parity=1: exactly 513 halt cycles; 256 reads $0200-$02FF alternate with 256 writes to $2004; bytes written equal the bytes read, in order.
- Same trigger with the halt cycle on parity=0: one ALIGN cycle inserted, 514 total, first read on a parity-0 cycle.
- Trigger followed by 2 more CPU write cycles before cpu_ren=1: the DMA waits in HALT_WAIT with rdy=0 and bus untouched, then proceeds as above.
- Page $FF transfer: last read address is $FFFF, then rdy=1 with no address wrap into $0000.
- Assert rst during READ of idx=$40: the next cycle has rdy=1, dma_active=0, strobes 0; a new $4014 write starts cleanly from idx 0.
